// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch path: buffered entries, exception info and
// the fetch-unit state.
package fetch_pkg;

    localparam logic [3:0] EXC_INST_MISALIGNED   = 4'd0;
    localparam logic [3:0] EXC_INST_ACCESS_FAULT = 4'd1;

    typedef struct packed {
        logic        valid;
        logic [3:0]  code;
        logic [31:0] value;
    } fetch_exception_t;

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        fetch_exception_t exception;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; DEPTH must be a power of two (>= 2).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW + 1)'(DEPTH));
        do_pop  = pop && !empty;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues word reads from the PC, pairs in-order responses
// with their PCs, buffers them for the core and flushes on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_exception_valid,
    input  logic [3:0]  mem_rsp_exception,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_exception_valid,
    output logic [3:0]  inst_exception,
    output logic [31:0] inst_exception_value
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state;
    logic [31:0]    pc;
    logic [31:0]    rsp_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_count;

    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_data;
    fetch_entry_t   shown;
    logic           fifo_push;
    logic           fifo_pop;

    logic [31:0]    in_flight;
    logic           rsp_fire;
    logic           req_fire;
    logic           misalign_push;
    logic           rsp_push;

    always_comb begin
        in_flight = 32'(fifo_count) + 32'(outstanding);
        rsp_fire  = mem_rsp_valid && (outstanding != '0);

        // slot reservation: buffered plus in-flight never exceeds the FIFO depth,
        // so every response always has a place to land
        mem_req_valid = reset && (state == RUN) && !redirect_valid
                        && (pc[1:0] == 2'b00)
                        && (32'(outstanding) < MAX_OUTSTANDING)
                        && (in_flight < FIFO_DEPTH);
        mem_req_addr  = pc;
        req_fire      = mem_req_valid && mem_req_ready;

        misalign_push = (state == RUN) && !redirect_valid && (pc[1:0] != 2'b00)
                        && (outstanding == '0) && !fifo_full;
        rsp_push      = rsp_fire && (drop_count == '0) && !redirect_valid;

        push_data = '0;
        if (misalign_push) begin
            push_data.pc              = pc;
            push_data.exception.valid = 1'b1;
            push_data.exception.code  = EXC_INST_MISALIGNED;
            push_data.exception.value = pc;
        end else begin
            push_data.inst = mem_rsp_data;
            push_data.pc   = rsp_pc;
            if (mem_rsp_exception_valid) begin
                push_data.exception.valid = 1'b1;
                push_data.exception.code  = mem_rsp_exception;
                push_data.exception.value = rsp_pc;
            end
        end

        fifo_push = misalign_push || rsp_push;
        fifo_pop  = !fifo_empty && inst_ready && !redirect_valid;

        shown                = fifo_empty ? '0 : fifo_head;
        inst_valid           = !fifo_empty;
        inst_data            = shown.inst;
        inst_pc              = shown.pc;
        inst_exception_valid = shown.exception.valid;
        inst_exception       = shown.exception.code;
        inst_exception_value = shown.exception.value;
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_data),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else if (redirect_valid) begin
            // every request still in flight is stale; a response arriving now is discarded
            state       <= RUN;
            pc          <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding - OW'(rsp_fire);
            drop_count  <= outstanding - OW'(rsp_fire);
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
            if (req_fire) pc <= pc + 32'd4;
            if (rsp_fire) begin
                if (drop_count != '0) begin
                    drop_count <= drop_count - OW'(1);
                end else begin
                    rsp_pc <= rsp_pc + 32'd4;
                    if (mem_rsp_exception_valid) state <= HALT;
                end
            end
            if (misalign_push) state <= HALT;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle memory model with request budget and
// response hold, and a scoreboard monitor checking every entry the core consumes.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_exception_valid = 1'b0;
    logic [3:0]  mem_rsp_exception = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_exception_valid;
    logic [3:0]  inst_exception;
    logic [31:0] inst_exception_value;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC        (32'h8000_0000),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .mem_req_valid           (mem_req_valid),
        .mem_req_ready           (mem_req_ready),
        .mem_req_addr            (mem_req_addr),
        .mem_rsp_valid           (mem_rsp_valid),
        .mem_rsp_data            (mem_rsp_data),
        .mem_rsp_exception_valid (mem_rsp_exception_valid),
        .mem_rsp_exception       (mem_rsp_exception),
        .inst_valid              (inst_valid),
        .inst_ready              (inst_ready),
        .inst_data               (inst_data),
        .inst_pc                 (inst_pc),
        .inst_exception_valid    (inst_exception_valid),
        .inst_exception          (inst_exception),
        .inst_exception_value    (inst_exception_value)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        exc_valid;
        logic [3:0]  code;
        logic [31:0] value;
    } exp_t;

    exp_t        exp_inst[$];
    logic [31:0] exp_req[$];
    logic [31:0] resp_q[$];

    int unsigned budget = 0;
    int unsigned accepted = 0;
    int unsigned answered = 0;
    int unsigned acc0;
    logic        rsp_hold = 1'b0;
    logic [31:0] fault_addr = 32'h0000_0001;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_inst(input logic [31:0] pc, input logic [31:0] data, input logic excv,
                             input logic [3:0] code, input logic [31:0] value);
        exp_t e;
        e.pc = pc; e.data = data; e.exc_valid = excv; e.code = code; e.value = value;
        exp_inst.push_back(e);
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        exp_req.push_back(pc);
        push_inst(pc, mem_word(pc), 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_req.size() != 0 || exp_inst.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_drain: timeout, %0d requests and %0d entries still expected",
                         name, exp_req.size(), exp_inst.size());
                exp_req.delete();
                exp_inst.delete();
                return;
            end
        end
    endtask

    task automatic wait_accepted(input string name, input int unsigned target);
        int n = 0;
        while (accepted < target) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_accept: timeout, got %0d accepted, expected %0d", name, accepted, target);
                return;
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // memory: request accepted at edge N is answered during cycle N+1, in order
    always begin : mem_model
        logic [31:0] a;
        @(negedge clk);
        #1;
        if (!reset) begin
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            resp_q.delete();
        end else begin
            if (!rsp_hold && resp_q.size() > 0) begin
                a = resp_q.pop_front();
                assert (accepted > answered) else $error("response driven with nothing outstanding");
                answered++;
                mem_rsp_valid           = 1'b1;
                mem_rsp_data            = mem_word(a);
                mem_rsp_exception_valid = (a == fault_addr);
                mem_rsp_exception       = (a == fault_addr) ? EXC_INST_ACCESS_FAULT : 4'd0;
            end else begin
                mem_rsp_valid           = 1'b0;
                mem_rsp_data            = '0;
                mem_rsp_exception_valid = 1'b0;
                mem_rsp_exception       = '0;
            end
            mem_req_ready = (budget > 0);
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL mem_req_addr: got request %h, expected none", mem_req_addr);
                end else begin
                    check("mem_req_addr", mem_req_addr, exp_req.pop_front());
                end
                resp_q.push_back(mem_req_addr);
                budget--;
                accepted++;
            end
        end
    end

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (reset && inst_valid && inst_ready && !redirect_valid) begin
            vectors++;
            if (exp_inst.size() == 0) begin
                miscompares++;
                $display("FAIL inst_pop: got entry pc=%h, expected none", inst_pc);
            end else begin
                e = exp_inst.pop_front();
                if (inst_pc !== e.pc || inst_data !== e.data || inst_exception_valid !== e.exc_valid
                    || inst_exception !== e.code || inst_exception_value !== e.value) begin
                    miscompares++;
                    $display("FAIL inst_entry: got pc=%h data=%h exc=%b code=%0d val=%h, expected pc=%h data=%h exc=%b code=%0d val=%h",
                             inst_pc, inst_data, inst_exception_valid, inst_exception, inst_exception_value,
                             e.pc, e.data, e.exc_valid, e.code, e.value);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({name, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({name, "_inst_data"}, inst_data, 32'd0);
        check({name, "_inst_pc"}, inst_pc, 32'd0);
        check({name, "_exc_valid"}, 32'(inst_exception_valid), 32'd0);
        check({name, "_exc_code"}, 32'(inst_exception), 32'd0);
        check({name, "_exc_value"}, inst_exception_value, 32'd0);
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        reset          = 1'b0;
        #3;
        check_idle_outputs("reset");

        // straight-line fetch
        @(negedge clk);
        push_fetch(32'h8000_0000);
        push_fetch(32'h8000_0004);
        push_fetch(32'h8000_0008);
        reset = 1'b1; inst_ready = 1'b1; budget = 3;
        wait_drain("seq");

        // core stall: only two slots can be claimed
        @(negedge clk);
        inst_ready = 1'b0; acc0 = accepted;
        push_fetch(32'h8000_000C);
        push_fetch(32'h8000_0010);
        push_fetch(32'h8000_0014);
        push_fetch(32'h8000_0018);
        budget = 4;
        wait_accepted("stall", acc0 + 2);
        repeat (4) @(negedge clk);
        check("stall_accepted", accepted - acc0, 32'd2);
        check("stall_req_valid", 32'(mem_req_valid), 32'd0);
        check("stall_head_pc", inst_pc, 32'h8000_000C);
        inst_ready = 1'b1;
        wait_drain("stall");

        // redirect with two stale requests in flight
        @(negedge clk);
        rsp_hold = 1'b1; acc0 = accepted;
        exp_req.push_back(32'h8000_001C);
        exp_req.push_back(32'h8000_0020);
        budget = 2;
        wait_accepted("stale", acc0 + 2);
        @(negedge clk);
        check("stale_req_valid", 32'(mem_req_valid), 32'd0);
        push_fetch(32'h8000_0100);
        push_fetch(32'h8000_0104);
        redirect_to(32'h8000_0100);
        rsp_hold = 1'b0; budget = 2;
        wait_drain("redirect");

        // misaligned redirect target
        @(negedge clk);
        push_inst(32'h8000_0102, 32'd0, 1'b1, EXC_INST_MISALIGNED, 32'h8000_0102);
        redirect_to(32'h8000_0102);
        acc0 = accepted; budget = 5;
        wait_drain("misalign");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("misalign_halt_req_valid", 32'(mem_req_valid), 32'd0);
        end
        check("misalign_accepted", accepted - acc0, 32'd0);
        budget = 0;

        // access fault on the third fetch
        @(negedge clk);
        fault_addr = 32'h8000_0008;
        push_fetch(32'h8000_0000);
        push_fetch(32'h8000_0004);
        exp_req.push_back(32'h8000_0008);
        push_inst(32'h8000_0008, mem_word(32'h8000_0008), 1'b1, EXC_INST_ACCESS_FAULT, 32'h8000_0008);
        redirect_to(32'h8000_0000);
        budget = 3;
        wait_drain("fault");
        @(negedge clk);
        acc0 = accepted; budget = 5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fault_halt_req_valid", 32'(mem_req_valid), 32'd0);
        end
        check("fault_accepted", accepted - acc0, 32'd0);
        budget = 0;
        @(negedge clk);
        fault_addr = 32'h0000_0001;
        push_fetch(32'h8000_0000);
        push_fetch(32'h8000_0004);
        redirect_to(32'h8000_0000);
        budget = 2;
        wait_drain("resume");

        // reset while the buffer is full
        @(negedge clk);
        inst_ready = 1'b0; acc0 = accepted;
        exp_req.push_back(32'h8000_0008);
        exp_req.push_back(32'h8000_000C);
        budget = 2;
        wait_accepted("fill", acc0 + 2);
        repeat (3) @(negedge clk);
        check("fill_inst_valid", 32'(inst_valid), 32'd1);
        check("fill_head_pc", inst_pc, 32'h8000_0008);
        check("fill_req_valid", 32'(mem_req_valid), 32'd0);
        reset = 1'b0;
        #2;
        check_idle_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        push_fetch(32'h8000_0000);
        reset = 1'b1; inst_ready = 1'b1; budget = 1;
        wait_drain("after_reset");
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
